// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          FETCH_ADDR_W = 14;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic                    valid;
        logic [FETCH_ADDR_W-1:0] tag;
        logic [31:0]             data;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Two-entry instruction tag store with hit, probe and victim logic.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] lookup_tag,
    input  logic [ADDR_W-1:0] probe_tag,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_tag,
    input  logic [31:0]       wr_data,
    output logic              hit,
    output logic [31:0]       hit_data,
    output logic              probe_hit
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [31:0]       data;
    } entry_t;

    entry_t     entry_q [2];
    entry_t     entry_d [2];
    logic [1:0] hit_vec;
    logic [1:0] probe_vec;
    logic       victim;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_entry
            assign hit_vec[i]   = entry_q[i].valid && (entry_q[i].tag == lookup_tag);
            assign probe_vec[i] = entry_q[i].valid && (entry_q[i].tag == probe_tag);
        end
    endgenerate

    assign hit       = |hit_vec;
    assign probe_hit = |probe_vec;
    assign hit_data  = hit_vec[0] ? entry_q[0].data :
                       hit_vec[1] ? entry_q[1].data : NOP_INSTR;

    // Keep the entry serving the current pc; otherwise refill entry 0.
    assign victim = hit_vec[0];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (flush) begin
            entry_d[0].valid = 1'b0;
            entry_d[1].valid = 1'b0;
        end else if (wr_en) begin
            entry_d[victim] = '{valid: 1'b1, tag: wr_tag, data: wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch front end: request FSM, prefetch control and core stall.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = FETCH_ADDR_W,
    parameter int PREFETCH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              stall,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemReady,
    input  logic              imemRvalid,
    input  logic [31:0]       imemRdata
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              drop_q, drop_d;

    logic [ADDR_W-1:0] pc_tag;
    logic [ADDR_W-1:0] next_tag;
    logic              hit;
    logic              probe_hit;
    logic [31:0]       hit_data;
    logic              wr_en;
    logic              unused_pc_bits;

    assign pc_tag         = pc[ADDR_W+1:2];
    assign next_tag       = pc_tag + ADDR_W'(1);
    assign unused_pc_bits = ^{pc[31:ADDR_W+2], pc[1:0]};

    fetch_buffer #(
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .lookup_tag (pc_tag),
        .probe_tag  (next_tag),
        .wr_en      (wr_en),
        .wr_tag     (addr_q),
        .wr_data    (imemRdata),
        .hit        (hit),
        .hit_data   (hit_data),
        .probe_hit  (probe_hit)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        req_d   = req_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!hit) begin
                    addr_d  = pc_tag;
                    req_d   = 1'b1;
                    state_d = REQ;
                end else if ((PREFETCH != 0) && !probe_hit) begin
                    addr_d  = next_tag;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imemReady) begin
                    req_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imemRvalid) begin
                    wr_en   = !drop_q && !flush;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // The response that ends WAIT consumes any pending drop.
        if ((state_q == WAIT) && imemRvalid) begin
            drop_d = 1'b0;
        end else if (flush && (state_q != IDLE)) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

    assign stall    = !hit;
    assign instr    = hit ? hit_data : NOP_INSTR;
    assign imemReq  = req_q;
    assign imemAddr = addr_q;

endmodule
`default_nettype wire
